// File: rtl/fma_ctrl_pkg.sv
// Shared types and defaults for the FMA pipeline controller.
// The stage record holds a tag field wide enough for any supported tag width.
package fma_ctrl_pkg;

    localparam int DEF_LAT = 3;
    localparam int DEF_TAG = 4;
    localparam int TAG_MAX = 16;

    typedef logic req_id_t;

    typedef struct packed {
        logic                vld;
        req_id_t             id;
        logic [TAG_MAX-1:0]  tag;
    } stage_rec_t;

endpackage

// File: rtl/fma_pipe_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on conflict the requester not named by the
// last-grant pointer wins; the pointer advances only when the grant is accepted.
module rr_arb2
    import fma_ctrl_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last,
    input  logic       accept,
    output req_id_t    gnt_id,
    output logic       gnt_any,
    output req_id_t    last_nxt
);

    always_comb begin
        gnt_any = |valid;
        case (valid)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last;
            default: gnt_id = 1'b0;
        endcase
        last_nxt = accept ? gnt_id : last;
    end

endmodule

// File: rtl/fma_pipe_ctrl.sv
// Issue/advance controller for a PARM_LAT-stage FMA datapath with two requesters,
// per-stage elastic stalls, flush, and id/tag tracking alongside the data.
module fma_pipe_ctrl
    import fma_ctrl_pkg::*;
#(
    parameter int PARM_LAT = DEF_LAT,
    parameter int PARM_TAG = DEF_TAG
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [2*PARM_TAG-1:0] req_tag_i,
    output logic                  op_sel_o,
    output logic [PARM_LAT-1:0]   stage_en_o,
    input  logic                  flush_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic                  resp_id_o,
    output logic [PARM_TAG-1:0]   resp_tag_o,
    output logic                  busy_o,
    output logic [2:0]            occ_o
);

    stage_rec_t          st [PARM_LAT];
    logic [PARM_LAT-1:0] vld;
    logic [PARM_LAT-1:0] adv;
    req_id_t             last_gnt;
    req_id_t             last_nxt;
    req_id_t             op_sel_q;
    req_id_t             gnt_id;
    logic                gnt_any;
    logic                active;
    logic                issue;
    logic [PARM_TAG-1:0] issue_tag;

    rr_arb2 u_arb (
        .valid    (req_valid_i),
        .last     (last_gnt),
        .accept   (issue),
        .gnt_id   (gnt_id),
        .gnt_any  (gnt_any),
        .last_nxt (last_nxt)
    );

    // Outputs are forced idle while in reset or flushing.
    assign active       = rst_ni & ~flush_i;
    assign resp_valid_o = vld[PARM_LAT-1] & ~flush_i;
    assign resp_id_o    = st[PARM_LAT-1].id;
    assign resp_tag_o   = PARM_TAG'(st[PARM_LAT-1].tag);
    assign busy_o       = |vld;
    assign issue        = gnt_any & adv[0] & active;
    assign issue_tag    = gnt_id ? req_tag_i[2*PARM_TAG-1:PARM_TAG] : req_tag_i[PARM_TAG-1:0];
    assign req_ready_o  = issue ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign op_sel_o     = rst_ni & (gnt_any ? gnt_id : op_sel_q);

    always_comb begin
        logic [2:0] cnt;
        cnt = '0;
        for (int k = 0; k < PARM_LAT; k++) begin
            vld[k] = st[k].vld;
            cnt    = cnt + 3'(st[k].vld);
        end
        occ_o = cnt;
    end

    // Advance ripples back from the output so bubbles are squeezed out.
    always_comb begin
        logic chain;
        chain = ~vld[PARM_LAT-1] | (resp_valid_o & resp_ready_i);
        adv[PARM_LAT-1] = chain;
        for (int k = PARM_LAT-2; k >= 0; k--) begin
            chain  = ~vld[k] | chain;
            adv[k] = chain;
        end
    end

    always_comb begin
        stage_en_o    = '0;
        stage_en_o[0] = issue;
        for (int k = 1; k < PARM_LAT; k++)
            stage_en_o[k] = adv[k] & vld[k-1] & active;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < PARM_LAT; k++)
                st[k] <= '0;
            last_gnt <= 1'b1;
            op_sel_q <= 1'b0;
        end else begin
            last_gnt <= last_nxt;
            if (gnt_any)
                op_sel_q <= gnt_id;
            if (flush_i) begin
                for (int k = 0; k < PARM_LAT; k++)
                    st[k].vld <= 1'b0;
            end else begin
                if (adv[0])
                    st[0].vld <= issue;
                if (issue) begin
                    st[0].id  <= gnt_id;
                    st[0].tag <= TAG_MAX'(issue_tag);
                end
                for (int k = 1; k < PARM_LAT; k++) begin
                    if (adv[k])
                        st[k].vld <= vld[k-1];
                    if (stage_en_o[k]) begin
                        st[k].id  <= st[k-1].id;
                        st[k].tag <= st[k-1].tag;
                    end
                end
            end
        end
    end

endmodule
